// File: rtl/nrisc_mem_initiator.sv
// Load/store initiator for the 8-bit nRisc data memory bank: one access in flight,
// registered strobes, variable-latency ack. Define NRISC_MEM_TIMEOUT_EN to abort stalled accesses.
module nrisc_mem_initiator #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t r_state, w_state_nxt;
  logic   r_write;
  logic   w_timeout;
  logic   w_finish;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef NRISC_MEM_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Limit is hit on the edge that would make the count reach TIMEOUT_CYCLES; ack on that edge wins.
  assign w_timeout = (r_state == S_ACCESS) && !mem_ack && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                                r_cnt <= '0;
    else if (r_state == S_IDLE)                  r_cnt <= '0;
    else if (r_state == S_ACCESS && !w_finish)   r_cnt <= r_cnt + 8'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_finish  = (r_state == S_ACCESS) && (mem_ack || w_timeout);
  assign req_ready = (r_state == S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_finish)  w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_write   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write   <= req_write;
          mem_addr  <= req_addr;
          mem_wdata <= req_wdata;
          mem_write <= req_write;
          mem_read  <= !req_write;
        end
        S_ACCESS: if (w_finish) begin
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err   <= w_timeout;
          // Stores leave rsp_rdata untouched; a timed-out load returns zero.
          if (!r_write) rsp_rdata <= mem_ack ? mem_rdata : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/nrisc_mem_initiator.md
Name: nrisc_mem_initiator

Overview:
- CPU-side load/store initiator for the 8-bit nRisc data memory bank.
- Accepts one load or store request from the datapath and drives the memory bank's read/write strobes, address and write data.
- Waits for the bank's acknowledge, then returns load data and completion status to the datapath.
- One transaction in flight at a time; the memory bank may take any number of cycles to acknowledge.

Parameters:
- ADDR_W, 8, address width in bits.
- DATA_W, 8, data width in bits.
- TIMEOUT_CYCLES, 15, maximum strobe cycles without acknowledge; range 1..255. Used only with NRISC_MEM_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active low.
- req_valid  in  1  datapath request present.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  initiator can accept a request.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_err  out  1  completion was a timeout; valid with rsp_valid.
- rsp_rdata  out  DATA_W  load data.
- mem_read  out  1  read strobe to memory bank.
- mem_write  out  1  write strobe to memory bank.
- mem_addr  out  ADDR_W  address to memory bank.
- mem_wdata  out  DATA_W  write data to memory bank.
- mem_rdata  in  DATA_W  read data from memory bank.
- mem_ack  in  1  memory bank completes the current access.

Behaviour:
- Reset: single clock; reset_n is asynchronous and active low.
  - State IDLE; req_ready=1.
  - rsp_valid, rsp_err, mem_read, mem_write = 0.
  - mem_addr, mem_wdata, rsp_rdata = 0.
  - Timeout counter = 0.
- Reset mid-operation: strobes drop immediately. No response is produced for the aborted transaction.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1 at a clock edge, latch req_write, req_addr and req_wdata into mem_addr, mem_wdata and an internal write flag, then go to ACCESS.
- ACCESS:
  - req_ready=0.
  - mem_write = latched write flag; mem_read = its inverse. The two strobes are never both 1.
  - mem_addr and mem_wdata are held stable.
  - mem_ack is sampled every clock edge. A combinational ack in the first ACCESS cycle is legal.
  - On ack of a load: rsp_rdata <= mem_rdata; go to DONE with rsp_err=0.
  - On ack of a store: rsp_rdata holds its prior value; go to DONE with rsp_err=0.
  - Strobes deassert in the cycle after the ack edge.
- DONE:
  - rsp_valid=1 for exactly one cycle; req_ready=0.
  - Go to IDLE on the next edge.
- Latency: request edge at cycle 0 → strobe during cycle 1 → with ack in cycle 1, rsp_valid in cycle 2 → req_ready again in cycle 3. Peak throughput is one access per 3 cycles.
- req_valid outside IDLE is ignored; the requester must hold the request until req_ready.
- mem_ack outside ACCESS is ignored.
- mem_rdata is sampled only on the ack edge of a load.
- All outputs are registered except req_ready, which is decoded from state.

Optional Feature:
- Macro: NRISC_MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES with mem_ack still 0, go to DONE with rsp_err=1. Strobes drop.
  - For a load, rsp_rdata <= 0. For a store, rsp_rdata holds.
  - An ack on the same edge the limit is reached wins: normal completion, rsp_err=0.
- Without the macro:
  - No counter; ACCESS waits indefinitely.
  - rsp_err is tied to 0.

Test Plan:
- Reset: hold reset_n=0 with strobes high mid-ACCESS → all strobes and rsp_* = 0 immediately; after release, req_ready=1.
- Store, zero wait: req_write=1, addr=0x12, wdata=0xA5, mem_ack tied 1 → mem_write=1 with mem_addr=0x12, mem_wdata=0xA5 for one cycle; rsp_valid in cycle 2, rsp_err=0.
- Load, 3 wait cycles: addr=0x12; ack asserted on the 4th ACCESS cycle with mem_rdata=0xA5 → mem_read high for 4 cycles; rsp_rdata=0xA5; rsp_valid one cycle.
- Back-to-back: req_valid held high with two queued requests → second accepted only when req_ready returns; strobes never overlap; mem_read and mem_write never both 1.
- Spurious inputs: mem_ack pulsed in IDLE, and req_valid toggled during ACCESS → no state change, no extra rsp_valid.
- Timeout with NRISC_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: load with ack never asserted → strobe for 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0x00. Without the macro, the strobe stays high after 100 cycles.
